cpu_mc_legv8: RTL

Multi-cycle, width-parametrised LEGv8 core with an internal register file and a single shared memory port using a req/ack handshake. It is the successor to the single-cycle datapath: control becomes an explicit FSM, and memory may insert wait states. It sits at the top of the CPU hierarchy, and the memory model or bus adapter sits beside it.

---
 rtl/legv8_pkg.sv | 67 ++++++
 rtl/regfile_32.sv | 44 ++++
 rtl/cpu_mc_legv8.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/legv8_pkg.sv
// Shared definitions for the multi-cycle LEGv8 core: opcodes, FSM states, ALU
// operation codes and the instruction classifier used by the control path.
package legv8_pkg;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [7:0]  OP_CBZ  = 8'b10110100;
    localparam logic [5:0]  OP_B    = 6'b000101;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_ORR = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    typedef enum logic [2:0] {
        I_NONE,
        I_RTYPE,
        I_LDUR,
        I_STUR,
        I_CBZ,
        I_B
    } iclass_t;

    function automatic iclass_t decode_class(input logic [31:0] ir);
        iclass_t c;
        c = I_NONE;
        if (ir[31:21] == OP_ADD || ir[31:21] == OP_SUB ||
            ir[31:21] == OP_AND || ir[31:21] == OP_ORR) begin
            c = I_RTYPE;
        end else if (ir[31:21] == OP_LDUR) begin
            c = I_LDUR;
        end else if (ir[31:21] == OP_STUR) begin
            c = I_STUR;
        end else if (ir[31:24] == OP_CBZ) begin
            c = I_CBZ;
        end else if (ir[31:26] == OP_B) begin
            c = I_B;
        end
        return c;
    endfunction

    // Loads and stores fall through to ADD for their address computation.
    function automatic logic [3:0] alu_op_of(input logic [10:0] opc);
        logic [3:0] op;
        case (opc)
            OP_AND:  op = ALU_AND;
            OP_ORR:  op = ALU_ORR;
            OP_SUB:  op = ALU_SUB;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/regfile_32.sv
// 32 x XLEN register file: two read ports, one debug read port, one write port.
// X31 always reads as zero and writes to it are discarded.
module regfile_32 #(
    parameter int unsigned XLEN = 64
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [4:0]      raddr1_i,
    output logic [XLEN-1:0] rdata1_o,
    input  logic [4:0]      raddr2_i,
    output logic [XLEN-1:0] rdata2_o,
    input  logic [4:0]      dbg_addr_i,
    output logic [XLEN-1:0] dbg_data_o,
    input  logic            we_i,
    input  logic [4:0]      waddr_i,
    input  logic [XLEN-1:0] wdata_i
);

    logic [XLEN-1:0] regs_q [31];
    logic [XLEN-1:0] regs_d [31];

    always_comb begin
        regs_d = regs_q;
        if (we_i && waddr_i != 5'd31) begin
            regs_d[waddr_i] = wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 31; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Reads see the pre-write contents; a same-cycle write lands on the next edge.
    assign rdata1_o   = (raddr1_i   == 5'd31) ? '0 : regs_q[raddr1_i];
    assign rdata2_o   = (raddr2_i   == 5'd31) ? '0 : regs_q[raddr2_i];
    assign dbg_data_o = (dbg_addr_i == 5'd31) ? '0 : regs_q[dbg_addr_i];

endmodule

// File: rtl/cpu_mc_legv8.sv
// Multi-cycle LEGv8 core (ADD/SUB/AND/ORR/LDUR/STUR/CBZ/B) with an FSM control path
// and one shared req/ack memory port used for both fetches and data accesses.
module cpu_mc_legv8
    import legv8_pkg::*;
#(
    parameter int unsigned     XLEN     = 64,
    parameter logic [XLEN-1:0] PC_RESET = '0
) (
    input  logic            CLOCK,
    input  logic            RESET_N,
    output logic            MEM_REQ,
    output logic            MEM_WE,
    output logic [XLEN-1:0] MEM_ADDR,
    output logic [XLEN-1:0] MEM_WDATA,
    input  logic [XLEN-1:0] MEM_RDATA,
    input  logic            MEM_ACK,
    output logic [XLEN-1:0] PC,
    output logic            RETIRE,
    output logic            HALTED,
    input  logic [4:0]      DBG_SEL,
    output logic [XLEN-1:0] DBG_DATA
);

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     ir_q, ir_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [XLEN-1:0] aluout_q, aluout_d;
    logic [XLEN-1:0] mdr_q, mdr_d;

    iclass_t         cls;
    logic [4:0]      rs1, rs2;
    logic [XLEN-1:0] rs1_data, rs2_data;
    logic [XLEN-1:0] imm9_x, off_cbz, off_b, pc_plus4;
    logic [XLEN-1:0] alu_b, alu_res;
    logic            rf_we;
    logic [XLEN-1:0] rf_wdata;
    logic            mem_req, mem_we, retire;
    logic [XLEN-1:0] mem_addr, mem_wdata;

    regfile_32 #(
        .XLEN (XLEN)
    ) u_regfile (
        .clk_i      (CLOCK),
        .rst_ni     (RESET_N),
        .raddr1_i   (rs1),
        .rdata1_o   (rs1_data),
        .raddr2_i   (rs2),
        .rdata2_o   (rs2_data),
        .dbg_addr_i (DBG_SEL),
        .dbg_data_o (DBG_DATA),
        .we_i       (rf_we),
        .waddr_i    (ir_q[4:0]),
        .wdata_i    (rf_wdata)
    );

    always_comb begin
        cls      = decode_class(ir_q);
        rs1      = ir_q[9:5];
        rs2      = (cls == I_RTYPE) ? ir_q[20:16] : ir_q[4:0];
        imm9_x   = {{(XLEN-9){ir_q[20]}}, ir_q[20:12]};
        off_cbz  = {{(XLEN-21){ir_q[23]}}, ir_q[23:5], 2'b00};
        off_b    = {{(XLEN-28){ir_q[25]}}, ir_q[25:0], 2'b00};
        pc_plus4 = pc_q + XLEN'(4);
        alu_b    = (cls == I_RTYPE) ? b_q : imm9_x;
        case (alu_op_of(ir_q[31:21]))
            ALU_AND: alu_res = a_q & alu_b;
            ALU_ORR: alu_res = a_q | alu_b;
            ALU_SUB: alu_res = a_q - alu_b;
            default: alu_res = a_q + alu_b;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        a_d       = a_q;
        b_d       = b_q;
        aluout_d  = aluout_q;
        mdr_d     = mdr_q;
        rf_we     = 1'b0;
        rf_wdata  = aluout_q;
        retire    = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            S_FETCH: begin
                mem_addr = pc_q;
                // A misaligned PC halts without ever raising a request.
                if (pc_q[1:0] != 2'b00) begin
                    state_d = S_HALT;
                end else begin
                    mem_req = 1'b1;
                    if (MEM_ACK) begin
                        ir_d    = MEM_RDATA[31:0];
                        state_d = S_DECODE;
                    end
                end
            end
            S_DECODE: begin
                a_d     = rs1_data;
                b_d     = rs2_data;
                state_d = (cls == I_NONE) ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                aluout_d = alu_res;
                case (cls)
                    I_CBZ: begin
                        pc_d    = (b_q == '0) ? pc_q + off_cbz : pc_plus4;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                    I_B: begin
                        pc_d    = pc_q + off_b;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                    I_LDUR, I_STUR: state_d = S_MEM;
                    default:        state_d = S_WB;
                endcase
            end
            S_MEM: begin
                mem_req   = 1'b1;
                mem_addr  = aluout_q;
                mem_we    = (cls == I_STUR);
                mem_wdata = b_q;
                if (MEM_ACK) begin
                    if (cls == I_STUR) begin
                        pc_d    = pc_plus4;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        mdr_d   = MEM_RDATA;
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                rf_we    = 1'b1;
                rf_wdata = (cls == I_LDUR) ? mdr_q : aluout_q;
                pc_d     = pc_plus4;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_HALT;
            end
        endcase
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= S_FETCH;
            pc_q     <= PC_RESET;
            ir_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            aluout_q <= '0;
            mdr_q    <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            a_q      <= a_d;
            b_q      <= b_d;
            aluout_q <= aluout_d;
            mdr_q    <= mdr_d;
        end
    end

    // Gating with RESET_N drops an in-flight request the moment reset asserts.
    assign MEM_REQ   = mem_req & RESET_N;
    assign MEM_WE    = mem_we;
    assign MEM_ADDR  = mem_addr;
    assign MEM_WDATA = mem_wdata;
    assign PC        = pc_q;
    assign RETIRE    = retire;
    assign HALTED    = (state_q == S_HALT);

endmodule
